// File: rtl/qmax_update_table.sv
// qmax_update_table
//   Per-state running-maximum Q store held in inferred block RAM.
//   The Q-update datapath pushes (state, candidate) pairs; the block performs
//   the read-compare-write itself, forwarding the in-flight result so that
//   back-to-back updates to one state behave exactly like spaced updates.
//   An independent 1-cycle read port serves action selection, and a clear
//   sweep writes INIT_VAL to every entry after reset or on request.
//
// Ports
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_clear             one-cycle pulse, starts a clear sweep (RUN only)
//   o_busy              high while the clear sweep runs
//   i_upd_valid/o_upd_ready/i_upd_addr/i_upd_data
//                       update request handshake, state index, candidate Q
//   o_upd_done          one-cycle pulse when an update commits
//   o_upd_addr/o_upd_max/o_upd_changed
//                       committed address, stored value, candidate was larger
//   i_rd_en/i_rd_addr   read request; o_rd_data/o_rd_valid one cycle later
module qmax_update_table #(
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    DEPTH      = 64,
    parameter bit                    SIGNED     = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    output logic                  o_busy,
    input  logic                  i_upd_valid,
    output logic                  o_upd_ready,
    input  logic [ADDR_WIDTH-1:0] i_upd_addr,
    input  logic [DATA_WIDTH-1:0] i_upd_data,
    output logic                  o_upd_done,
    output logic [ADDR_WIDTH-1:0] o_upd_addr,
    output logic [DATA_WIDTH-1:0] o_upd_max,
    output logic                  o_upd_changed,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic                  run;
    logic                  acc_p0;
    logic                  vld_p1;
    logic                  fwd_p1;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [DATA_WIDTH-1:0] rdq_p1;
    logic [DATA_WIDTH-1:0] fwd_val_p1;
    logic [DATA_WIDTH-1:0] old_p1;
    logic [DATA_WIDTH-1:0] max_p1;
    logic                  gt_p1;
    logic                  we_p1;
    logic                  rd_hit;

    // Strict greater-than, two's-complement or unsigned depending on SIGNED.
    function automatic logic greater(input logic [DATA_WIDTH-1:0] a,
                                     input logic [DATA_WIDTH-1:0] b);
        logic signed [DATA_WIDTH-1:0] sa;
        logic signed [DATA_WIDTH-1:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        if (SIGNED) return sa > sb;
        return a > b;
    endfunction

    // ---------------- control FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                if (cnt == LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR_WIDTH'(1);
                end
            end
            RUN: begin
                if (i_clear) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign run         = (state == RUN);
    assign o_busy      = (state == CLEAR);
    assign o_upd_ready = run;

    // A clear pulse drops both the update being accepted and the one
    // currently in its compare/write cycle.
    assign acc_p0 = i_upd_valid && run && !i_clear;
    assign we_p1  = vld_p1 && run && !i_clear;

    // ---------------- stage p0 -> p1: accept, BRAM read ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p1 <= 1'b0;
            fwd_p1 <= 1'b0;
        end else begin
            vld_p1 <= acc_p0;
            // The BRAM read this cycle misses the write of the update now in
            // its compare stage; remember to take that result instead.
            fwd_p1 <= acc_p0 && we_p1 && (addr_p1 == i_upd_addr);
        end
    end

    always_ff @(posedge i_clk) begin
        addr_p1    <= i_upd_addr;
        data_p1    <= i_upd_data;
        rdq_p1     <= mem[i_upd_addr];
        fwd_val_p1 <= max_p1;
    end

    // ---------------- stage p1: compare, write ----------------
    always_comb begin
        old_p1 = fwd_p1 ? fwd_val_p1 : rdq_p1;
        gt_p1  = greater(data_p1, old_p1);
        max_p1 = gt_p1 ? data_p1 : old_p1;
    end

    // Single write port shared by the clear sweep and the update pipeline.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (state == CLEAR) begin
                mem[cnt] <= INIT_VAL;
            end else if (we_p1) begin
                mem[addr_p1] <= max_p1;
            end
        end
    end

    // ---------------- stage p2: commit report ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_upd_done    <= 1'b0;
            o_upd_changed <= 1'b0;
            o_upd_addr    <= '0;
            o_upd_max     <= '0;
        end else begin
            o_upd_done    <= we_p1;
            o_upd_changed <= we_p1 && gt_p1;
            if (we_p1) begin
                o_upd_addr <= addr_p1;
                o_upd_max  <= max_p1;
            end
        end
    end

    // ---------------- read port ----------------
    // Write-first: a read of the entry being written this cycle sees the new value.
    assign rd_hit = we_p1 && (addr_p1 == i_rd_addr);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            o_rd_valid <= i_rd_en && run;
            if (i_rd_en && run) begin
                o_rd_data <= rd_hit ? max_p1 : mem[i_rd_addr];
            end
        end
    end

endmodule
